// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline registers and hazard_ctrl.
// The pipeline side is the master; the controller is the slave.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             idex_memread_i;
  logic [REG_W-1:0] idex_rt_i;
  logic             idex_mul_i;
  logic [REG_W-1:0] ifid_rs_i;
  logic [REG_W-1:0] ifid_rt_i;
  logic             ifid_rt_used_i;
  logic             branch_taken_i;
  logic             jump_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_flush_o;
  logic             idex_hold_o;
  logic             exmem_flush_o;
  logic             busy_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output idex_memread_i, idex_rt_i, idex_mul_i, ifid_rs_i, ifid_rt_i,
           ifid_rt_used_i, branch_taken_i, jump_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
           idex_hold_o, exmem_flush_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  idex_memread_i, idex_rt_i, idex_mul_i, ifid_rs_i, ifid_rt_i,
           ifid_rt_used_i, branch_taken_i, jump_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
           idex_hold_o, exmem_flush_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: multi-cycle load-use and
// multiplier stalls, branch/jump flushing and a saturating stall counter.
module hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, LD_STALL, MUL_BUSY} state_e;

  localparam logic [3:0] LD_CNT  = 4'(LOAD_LAT - 1);
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu;
  logic             pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_flush;

  // Register zero never carries a real dependency.
  always_comb begin
    lu = hz.idex_memread_i && (hz.idex_rt_i != {REG_W{1'b0}}) &&
         ((hz.ifid_rs_i == hz.idex_rt_i) ||
          (hz.ifid_rt_used_i && (hz.ifid_rt_i == hz.idex_rt_i)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hz.branch_taken_i) begin
      state_d = RUN;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        MUL_BUSY, LD_STALL: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RUN;
        end
        default: begin
          if (hz.idex_mul_i) begin
            if (MUL_LAT > 1) begin
              state_d = MUL_BUSY;
              cnt_d   = MUL_CNT;
            end
          end else if (lu) begin
            if (LOAD_LAT > 1) begin
              state_d = LD_STALL;
              cnt_d   = LD_CNT;
            end
          end
        end
      endcase
    end
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Multiply takes precedence over load-use when both are flagged in RUN.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    idex_hold   = 1'b0;
    exmem_flush = 1'b0;
    if (!rst_i) begin
      if (hz.branch_taken_i) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (state_q == MUL_BUSY || (state_q == RUN && hz.idex_mul_i)) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_hold   = 1'b1;
        exmem_flush = 1'b1;
      end else if (state_q == LD_STALL || (state_q == RUN && lu)) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_flush  = 1'b1;
      end else if (hz.jump_i) begin
        ifid_flush  = 1'b1;
      end
    end
  end

  assign hz.pc_write_o    = pc_write;
  assign hz.ifid_write_o  = ifid_write;
  assign hz.ifid_flush_o  = ifid_flush;
  assign hz.idex_flush_o  = idex_flush;
  assign hz.idex_hold_o   = idex_hold;
  assign hz.exmem_flush_o = exmem_flush;
  assign hz.busy_o        = (state_q != RUN);
  assign hz.stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core; it replaces the single-cycle combinational hazard detector between the IF/ID, ID/EX and EX/MEM registers. It adds the following on top of load-use stalls and branch/jump flushing:
- multi-cycle load-use stalls (configurable memory latency);
- a multi-cycle EX-occupancy stall for the iterative multiplier;
- register-zero hazard suppression;
- a saturating stall-cycle performance counter.

## Interface
- REG_W, 5, register-index width
- LOAD_LAT, 1, load-use stall cycles (1..15)
- MUL_LAT, 4, cycles the multiplier occupies EX (1..15)
- CNT_W, 16, stall counter width
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- idex_memread_i  in  1  instruction in EX is a load
- idex_rt_i  in  REG_W  load destination in EX
- idex_mul_i  in  1  instruction in EX is a multiply
- ifid_rs_i  in  REG_W  rs of instruction in ID
- ifid_rt_i  in  REG_W  rt of instruction in ID
- ifid_rt_used_i  in  1  ID instruction reads rt (0 for I-type immediates)
- branch_taken_i  in  1  taken branch resolved at EX/MEM
- jump_i  in  1  jump decoded in ID
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  zero IF/ID
- idex_flush_o  out  1  load bubble into ID/EX
- idex_hold_o  out  1  ID/EX keeps its contents
- exmem_flush_o  out  1  load bubble into EX/MEM
- busy_o  out  1  state is not RUN
- stall_cnt_o  out  CNT_W  total stall cycles since reset

## Operation
- States: RUN, LD_STALL, MUL_BUSY. There is a 4-bit down-counter `cnt`.
- The load-use condition is `lu`:
  - `idex_memread_i` is high;
  - `idex_rt_i` is not 0;
  - and either `ifid_rs_i == idex_rt_i`, or `ifid_rt_used_i` is high and `ifid_rt_i == idex_rt_i`.
- Default outputs: pc_write=1, ifid_write=1, all flush and hold outputs 0.
- Stall output set `STALL`: pc_write=0, ifid_write=0.
- Priority, evaluated each cycle:
  1. rst_i.
  2. branch_taken_i: drive pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1. Next state is RUN and `cnt` is cleared. This applies from any state.
  3. MUL_BUSY: drive STALL plus idex_hold=1 and exmem_flush=1. Decrement `cnt`; when `cnt==1`, go to RUN.
  4. LD_STALL: drive STALL plus idex_flush=1. Decrement `cnt`; when `cnt==1`, go to RUN.
  5. RUN with idex_mul_i: drive as for MUL_BUSY. If MUL_LAT>1, go to MUL_BUSY with `cnt=MUL_LAT-1`.
  6. RUN with lu: drive as for LD_STALL. If LOAD_LAT>1, go to LD_STALL with `cnt=LOAD_LAT-1`.
  7. RUN with jump_i: drive ifid_flush=1 only.
  8. Otherwise: default outputs.
- Load-use beats jump: a jump that is stalled in ID fires on the first cycle after the stall ends.
- idex_mul_i and idex_memread_i are never both high. If they are, multiply wins.
- `lu`, jump_i and idex_mul_i are ignored outside RUN.
- busy_o = (state != RUN).
- stall_cnt_o increments by 1 on every cycle where pc_write_o=0 and rst_i=0. It saturates at all-ones.

## Timing
- All outputs except stall_cnt_o and busy_o are combinational from state, `cnt` and the inputs.
- State, `cnt` and stall_cnt_o update on the rising edge of clk_i.
- Reset values (rst_i high at the edge):
  - state=RUN, cnt=0, stall_cnt_o=0, busy_o=0.
  - While rst_i is high, outputs are forced to the default set and all inputs are ignored.
- Load-use costs exactly LOAD_LAT stall cycles, i.e. LOAD_LAT bubbles. The cycle that detects it counts as the first.
- A multiply costs exactly MUL_LAT frozen cycles, the detection cycle included. ID/EX is held throughout.
- Branch mid-stall: the stall is aborted in that same cycle. The next cycle is RUN with no residual stall.
- Reset mid-stall: the next cycle is RUN, and stall_cnt_o is 0.

## Test plan
- LOAD_LAT=1: lw $3 in EX with ID `add rs=3` → one cycle of pc_write=0, idex_flush=1. Next cycle shows the default outputs; stall_cnt_o=1.
- LOAD_LAT=3: lw $5 with ID rt=5 and ifid_rt_used=1 → 3 consecutive stall cycles, busy_o high for cycles 2–3, stall_cnt_o=3. Repeat with ifid_rt_used=0 → no stall.
- idex_rt=0 matching ifid_rs=0 with memread=1 → no stall.
- MUL_LAT=4: idex_mul=1 for one cycle → 4 cycles of idex_hold=1, exmem_flush=1, pc_write=0. Fifth cycle is RUN.
- During the 2nd MUL_BUSY cycle, assert branch_taken → that cycle shows all three flushes with pc_write=1. Next cycle has busy_o=0 and stall_cnt_o=1.
- Load-use and jump_i in the same cycle → stall only, ifid_flush=0. Jump flush occurs the first cycle after the stall. With CNT_W=2, drive 5 stall cycles → stall_cnt_o holds 3.
